// File: rtl/codel_pkg.sv
// rtl/codel_pkg.sv - state encoding and default constants for the CoDel dequeue stage
package codel_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      OBSERVE  = 2'd1,
      DROPPING = 2'd2
   } codel_state_e;

   localparam int DEFAULT_TS_WIDTH = 16;
   localparam int DEFAULT_TARGET   = 5;
   localparam int DEFAULT_INTERVAL = 100;

endpackage

// File: rtl/codel_dequeue_counter.sv
// rtl/codel_dequeue_counter.sv - modulo-NUM_COUNT up counter with synchronous active-high reset
module codel_dequeue_counter #(
   parameter int  NUM_COUNT = 65536,
   localparam int W         = (NUM_COUNT > 1) ? $clog2(NUM_COUNT) : 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i__inc,
   output logic [W-1:0] o__count
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else if (i__inc) begin
         count_q <= (count_q == W'(NUM_COUNT - 1)) ? '0 : count_q + W'(1);
      end
   end

   assign o__count = count_q;

endmodule

// File: rtl/codel_dequeue.sv
// rtl/codel_dequeue.sv - CoDel head-drop stage between an FWFT FIFO and a one-entry output register
module codel_dequeue
   import codel_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int TS_WIDTH   = DEFAULT_TS_WIDTH,
   parameter int TARGET     = DEFAULT_TARGET,
   parameter int INTERVAL   = DEFAULT_INTERVAL
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i__head_valid,
   input  logic [DATA_WIDTH-1:0] i__head_data,
   output logic                  o__head_ready,
   output logic                  o__data_out_valid,
   output logic [DATA_WIDTH-1:0] o__data_out,
   input  logic                  i__data_out_ready,
   output logic [TS_WIDTH-1:0]   o__now,
   output logic                  o__drop_pulse,
   output logic                  o__dropping,
   output logic [31:0]           o__drop_count
);

   localparam logic [TS_WIDTH-1:0] TARGET_TS   = TS_WIDTH'(TARGET);
   localparam logic [TS_WIDTH-1:0] INTERVAL_TS = TS_WIDTH'(INTERVAL);

   codel_state_e          state_q, state_d;
   logic [TS_WIDTH-1:0]   first_above_q, first_above_d;
   logic [TS_WIDTH-1:0]   drop_next_q, drop_next_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [31:0]           drop_count_q, drop_count_d;

   logic [TS_WIDTH-1:0]   now;
   logic [TS_WIDTH-1:0]   sojourn;
   logic [TS_WIDTH-1:0]   first_above_diff;
   logic [TS_WIDTH-1:0]   drop_next_diff;
   logic                  pop;
   logic                  above;
   logic                  first_above_hit;
   logic                  drop_next_hit;
   logic                  drop;

   codel_dequeue_counter #(
      .NUM_COUNT (1 << TS_WIDTH)
   ) u_now_counter (
      .clk      (clk),
      .reset    (~reset),
      .i__inc   (1'b1),
      .o__count (now)
   );

   assign o__head_ready = reset & (~out_valid_q | i__data_out_ready);
   assign pop           = i__head_valid & o__head_ready;
   assign sojourn       = now - i__head_data[TS_WIDTH-1:0];
   assign above         = (sojourn >= TARGET_TS);

   // A deadline is reached once the signed distance past it is non-negative, which survives wrap.
   assign first_above_diff = now - first_above_q;
   assign drop_next_diff   = now - drop_next_q;
   assign first_above_hit  = ~first_above_diff[TS_WIDTH-1];
   assign drop_next_hit    = ~drop_next_diff[TS_WIDTH-1];

   always_comb begin
      state_d       = state_q;
      first_above_d = first_above_q;
      drop_next_d   = drop_next_q;
      drop          = 1'b0;
      case (state_q)
         IDLE: begin
            if (pop && above) begin
               state_d       = OBSERVE;
               first_above_d = now + INTERVAL_TS;
            end
         end
         OBSERVE: begin
            if (!i__head_valid) begin
               state_d = IDLE;
            end else if (pop) begin
               if (!above) begin
                  state_d = IDLE;
               end else if (first_above_hit) begin
                  drop        = 1'b1;
                  state_d     = DROPPING;
                  drop_next_d = now + INTERVAL_TS;
               end
            end
         end
         DROPPING: begin
            if (!i__head_valid) begin
               state_d = IDLE;
            end else if (pop) begin
               if (!above) begin
                  state_d = IDLE;
               end else if (drop_next_hit) begin
                  drop        = 1'b1;
                  drop_next_d = drop_next_q + INTERVAL_TS;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      drop_count_d = drop_count_q;
      if (pop && !drop) begin
         out_valid_d = 1'b1;
         out_data_d  = i__head_data;
      end else if (i__data_out_ready) begin
         out_valid_d = 1'b0;
      end
      if (drop && (drop_count_q != '1)) begin
         drop_count_d = drop_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= IDLE;
         first_above_q <= '0;
         drop_next_q   <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         drop_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         first_above_q <= first_above_d;
         drop_next_q   <= drop_next_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         drop_count_q  <= drop_count_d;
      end
   end

   assign o__now            = now;
   assign o__data_out_valid = out_valid_q;
   assign o__data_out       = out_data_q;
   assign o__drop_pulse     = drop;
   assign o__dropping       = reset & (state_q == DROPPING);
   assign o__drop_count     = drop_count_q;

endmodule

// File: tb/tb_codel_dequeue.sv
// tb/tb_codel_dequeue.sv - directed self-checking bench for codel_dequeue
module tb_codel_dequeue;
   import codel_pkg::*;

   logic        clk;
   logic        reset;
   logic        head_valid;
   logic [63:0] head_data;
   logic        head_ready;
   logic        out_valid;
   logic [63:0] data_out;
   logic        out_ready;
   logic [15:0] now;
   logic        drop_pulse;
   logic        dropping;
   logic [31:0] drop_count;

   logic [15:0] exp_now;
   logic [63:0] last_entry;
   logic [63:0] prev_entry;
   logic [63:0] saved_entry;
   logic        prev_dropped;
   logic        exp_drop;
   int          checks;
   int          errors;
   int          spins;

   codel_dequeue dut (
      .clk               (clk),
      .reset             (reset),
      .i__head_valid     (head_valid),
      .i__head_data      (head_data),
      .o__head_ready     (head_ready),
      .o__data_out_valid (out_valid),
      .o__data_out       (data_out),
      .i__data_out_ready (out_ready),
      .o__now            (now),
      .o__drop_pulse     (drop_pulse),
      .o__dropping       (dropping),
      .o__drop_count     (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) exp_now <= reset ? exp_now + 16'd1 : 16'd0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic present(input int tag, input int soj);
      head_valid = 1'b1;
      head_data  = {48'(tag), exp_now - 16'(soj)};
      last_entry = head_data;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b0;
      head_valid = 1'b0;
      head_data  = '0;
      out_ready  = 1'b1;
      last_entry = '0;

      @(negedge clk);
      @(negedge clk);
      check("rst_now", 64'(now), 64'h0);
      check("rst_valid", 64'(out_valid), 64'h0);
      check("rst_count", 64'(drop_count), 64'h0);
      check("rst_state", 64'(dut.state_q), 64'(IDLE));
      head_valid = 1'b1;
      head_data  = 64'h1234;
      #1;
      check("rst_head_ready", 64'(head_ready), 64'h0);
      check("rst_pulse", 64'(drop_pulse), 64'h0);
      check("rst_dropping", 64'(dropping), 64'h0);
      head_valid = 1'b0;
      reset      = 1'b1;

      // timestamp wrap
      spins = 0;
      while (exp_now != 16'hFFFF && spins < 70000) begin
         @(negedge clk);
         spins++;
      end
      check("now_ffff", 64'(now), 64'hFFFF);
      @(negedge clk);
      check("now_wrap", 64'(now), 64'h0);
      head_valid = 1'b1;
      head_data  = {48'd1, 16'hFFFC};
      last_entry = head_data;
      #1;
      check("wrap_head_ready", 64'(head_ready), 64'h1);
      @(negedge clk);
      check("wrap_soj4_state", 64'(dut.state_q), 64'(IDLE));
      check("wrap_soj4_data", data_out, last_entry);
      head_data  = {48'd2, 16'hFFF1};
      last_entry = head_data;
      @(negedge clk);
      check("wrap_soj16_state", 64'(dut.state_q), 64'(OBSERVE));
      check("wrap_soj16_data", data_out, last_entry);
      head_valid = 1'b0;
      @(negedge clk);
      check("empty_to_idle", 64'(dut.state_q), 64'(IDLE));

      // short sojourn forwarded with one cycle latency
      present(3, 2);
      #1;
      check("fwd_head_ready", 64'(head_ready), 64'h1);
      check("fwd_pulse", 64'(drop_pulse), 64'h0);
      @(negedge clk);
      head_valid = 1'b0;
      check("fwd_valid", 64'(out_valid), 64'h1);
      check("fwd_data", data_out, last_entry);
      check("fwd_state", 64'(dut.state_q), 64'(IDLE));
      check("fwd_count", 64'(drop_count), 64'h0);
      @(negedge clk);
      check("fwd_unload", 64'(out_valid), 64'h0);

      // sustained sojourn 10: drops at pops 100 and 200
      prev_dropped = 1'b0;
      prev_entry   = '0;
      for (int k = 0; k <= 200; k++) begin
         exp_drop = (k == 100) || (k == 200);
         present(100 + k, 10);
         #1;
         check("soj10_pulse", 64'(drop_pulse), 64'(exp_drop));
         if (k > 0) begin
            check("soj10_valid", 64'(out_valid), 64'(!prev_dropped));
            if (!prev_dropped) check("soj10_data", data_out, prev_entry);
         end
         if (k == 1) check("soj10_observe", 64'(dut.state_q), 64'(OBSERVE));
         if (k == 101) begin
            check("soj10_dropping_state", 64'(dut.state_q), 64'(DROPPING));
            check("soj10_dropping_flag", 64'(dropping), 64'h1);
            check("soj10_count1", 64'(drop_count), 64'h1);
         end
         prev_entry   = last_entry;
         prev_dropped = exp_drop;
         @(negedge clk);
      end
      check("soj10_count2", 64'(drop_count), 64'h2);
      check("soj10_still_dropping", 64'(dut.state_q), 64'(DROPPING));
      check("soj10_last_dropped", 64'(out_valid), 64'h0);

      // low sojourn while dropping ends the episode
      present(900, 3);
      #1;
      check("exit_pulse", 64'(drop_pulse), 64'h0);
      @(negedge clk);
      check("exit_valid", 64'(out_valid), 64'h1);
      check("exit_data", data_out, last_entry);
      check("exit_state", 64'(dut.state_q), 64'(IDLE));
      check("exit_dropping", 64'(dropping), 64'h0);
      saved_entry = last_entry;

      // downstream backpressure holds the output register
      out_ready = 1'b0;
      present(901, 2);
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_head_ready", 64'(head_ready), 64'h0);
         check("bp_valid", 64'(out_valid), 64'h1);
         check("bp_data", data_out, saved_entry);
         @(negedge clk);
      end
      present(901, 2);
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 64'(head_ready), 64'h1);
      @(negedge clk);
      head_valid = 1'b0;
      check("bp_release_data", data_out, last_entry);
      check("bp_count", 64'(drop_count), 64'h2);
      check("bp_state", 64'(dut.state_q), 64'(IDLE));

      // reset in the middle of a dropping episode
      for (int k = 0; k <= 101; k++) begin
         present(300 + k, 10);
         #1;
         if (k == 100) check("rd_pulse", 64'(drop_pulse), 64'h1);
         @(negedge clk);
      end
      check("rd_state", 64'(dut.state_q), 64'(DROPPING));
      check("rd_dropping", 64'(dropping), 64'h1);
      check("rd_valid", 64'(out_valid), 64'h1);
      check("rd_data", data_out, last_entry);
      check("rd_count", 64'(drop_count), 64'h3);
      out_ready = 1'b0;
      reset     = 1'b0;
      #1;
      check("rd_head_ready", 64'(head_ready), 64'h0);
      check("rd_pulse_gated", 64'(drop_pulse), 64'h0);
      check("rd_dropping_gated", 64'(dropping), 64'h0);
      @(negedge clk);
      check("rd_after_state", 64'(dut.state_q), 64'(IDLE));
      check("rd_after_valid", 64'(out_valid), 64'h0);
      check("rd_after_count", 64'(drop_count), 64'h0);
      check("rd_after_now", 64'(now), 64'h0);
      check("rd_after_dropping", 64'(dropping), 64'h0);
      reset      = 1'b1;
      head_valid = 1'b0;
      out_ready  = 1'b1;
      @(negedge clk);
      check("rd_now_restart", 64'(now), 64'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
